// File: rtl/tx_arb_pkg.sv
// Shared types for the transmit key arbiter: FSM states, owner codes and the
// fixed-priority source picker.
package tx_arb_pkg;

  localparam int CNT_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    RELAY_ON,
    ACTIVE,
    HANG,
    RELEASE,
    LOCKOUT
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_KEYER = 2'd1,
    OWN_HOST  = 2'd2,
    OWN_EXT   = 2'd3
  } owner_t;

  // Fixed priority: keyer > host > external PTT.
  function automatic owner_t pick_owner(input logic rk, input logic rh, input logic re);
    if (rk)      return OWN_KEYER;
    else if (rh) return OWN_HOST;
    else if (re) return OWN_EXT;
    else         return OWN_NONE;
  endfunction

endpackage

// File: rtl/tx_arb_timer.sv
// Loadable tick down-counter shared by every timed arbiter state.
// A load wins over the decrement; the count rests at zero.
module tx_arb_timer
  import tx_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rstb,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tx_key_arbiter.sv
// Transmit key arbiter: picks keyer/host/external PTT as TX owner and sequences
// relay settle, RF keying, hang, release guard and stuck-key lockout on 1 ms ticks.
module tx_key_arbiter
  import tx_arb_pkg::*;
#(
  parameter int WDT_W    = 16,
  parameter int GUARD_MS = 5
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             tick_1ms,
  input  logic             req_keyer,
  input  logic             key_keyer,
  input  logic             req_host,
  input  logic             key_host,
  input  logic             ptt_ext_n,
  input  logic [9:0]       relay_dly,
  input  logic [9:0]       hang_time,
  input  logic [WDT_W-1:0] wdt_ms,
  output logic             tx_on,
  output logic             rf_key,
  output logic [1:0]       owner,
  output logic             grant_pulse,
  output logic             release_pulse,
  output logic             wdt_trip
);

  localparam logic [CNT_W-1:0] GUARD_V = CNT_W'(GUARD_MS);

  arb_state_t       state, state_nxt;
  owner_t           owner_q, owner_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_hit;
  logic             req_ext;
  logic             any_req;
  logic             own_req;
  logic             own_carrier;
  logic             own_hold;
  logic             higher_req;
  logic             tx_on_nxt;
  logic             rf_key_nxt;

  assign req_ext = ~ptt_ext_n;
  assign any_req = req_keyer | req_host | req_ext;
  assign wdt_hit = (wdt_ms != '0) && (wdt_cnt >= wdt_ms);

  // External PTT never keys a carrier, but its held request is what keeps a
  // phone transmission in ACTIVE rather than draining through HANG.
  always_comb begin
    own_req     = 1'b0;
    own_carrier = 1'b0;
    own_hold    = 1'b0;
    higher_req  = 1'b0;
    case (owner_q)
      OWN_KEYER: begin
        own_req     = req_keyer;
        own_carrier = key_keyer;
        own_hold    = key_keyer;
      end
      OWN_HOST: begin
        own_req     = req_host;
        own_carrier = key_host;
        own_hold    = key_host;
        higher_req  = req_keyer;
      end
      OWN_EXT: begin
        own_req     = req_ext;
        own_hold    = req_ext;
        higher_req  = req_keyer | req_host;
      end
      default: ;
    endcase
  end

  // NOTE: every combinational output gets a default first so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner_q;
    load      = 1'b0;
    load_val  = '0;
    if (tick_1ms) begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state_nxt = RELAY_ON;
            owner_nxt = pick_owner(req_keyer, req_host, req_ext);
            load      = 1'b1;
            load_val  = relay_dly;
          end
        end
        RELAY_ON: begin
          if (!own_req)      state_nxt = RELEASE;
          else if (cnt_zero) state_nxt = ACTIVE;
        end
        ACTIVE: begin
          if (wdt_hit) begin
            state_nxt = LOCKOUT;
          end else if (!own_req) begin
            state_nxt = RELEASE;
          end else if (!own_hold) begin
            state_nxt = HANG;
            load      = 1'b1;
            load_val  = hang_time;
          end
        end
        HANG: begin
          if (higher_req) begin
            state_nxt = ACTIVE;
            owner_nxt = pick_owner(req_keyer, req_host, req_ext);
          end else if (!own_req) begin
            state_nxt = RELEASE;
          end else if (own_hold) begin
            state_nxt = ACTIVE;
          end else if (cnt_zero) begin
            state_nxt = RELEASE;
          end
        end
        RELEASE: begin
          if (cnt_zero) state_nxt = IDLE;
        end
        LOCKOUT: begin
          if (!any_req) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase

      if ((state_nxt == RELEASE) && (state != RELEASE)) begin
        load      = 1'b1;
        load_val  = GUARD_V;
        owner_nxt = OWN_NONE;
      end
      if (state_nxt == LOCKOUT) owner_nxt = OWN_NONE;
    end
  end

  assign tx_on_nxt  = (state == RELAY_ON) || (state == ACTIVE) || (state == HANG);
  // Carrier follows the owner key every clk; the watchdog kills it immediately.
  assign rf_key_nxt = (state == ACTIVE) && own_carrier && !wdt_hit;

  tx_arb_timer u_timer (
    .clk      (clk),
    .rstb     (rstb),
    .tick     (tick_1ms),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state         <= IDLE;
      owner_q       <= OWN_NONE;
      tx_on         <= 1'b0;
      rf_key        <= 1'b0;
      grant_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      wdt_trip      <= 1'b0;
      wdt_cnt       <= '0;
    end else begin
      state         <= state_nxt;
      owner_q       <= owner_nxt;
      tx_on         <= tx_on_nxt;
      rf_key        <= rf_key_nxt;
      grant_pulse   <= (owner_q == OWN_NONE) && (owner_nxt != OWN_NONE);
      release_pulse <= tx_on && !tx_on_nxt;

      if ((state_nxt == LOCKOUT) && (state != LOCKOUT)) wdt_trip <= 1'b1;
      else if ((state_nxt == IDLE) && (state != IDLE))  wdt_trip <= 1'b0;

      // Key-down time in ticks, saturating at the limit; any key-up tick clears it.
      if (tick_1ms) begin
        if (!rf_key)             wdt_cnt <= '0;
        else if (wdt_cnt < wdt_ms) wdt_cnt <= wdt_cnt + WDT_W'(1);
      end
    end
  end

  assign owner = owner_q;

endmodule
